// File: rtl/serial_rx_pkg.sv
// Shared types and line levels for the serial word receiver.
package serial_rx_pkg;

   typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, BREAK} rx_state_t;

   localparam logic SIN_IDLE  = 1'b1;
   localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/rx_shift_reg.sv
// W-bit right-shift deserialiser with a running XOR of every bit shifted in.
module rx_shift_reg #(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_clr,
   input  logic         i_shift,
   input  logic         i_bit,
   output logic [W-1:0] o_data,
   output logic         o_acc
);

   logic [W-1:0] sr_q, sr_d;
   logic         acc_q, acc_d;

   always_comb begin
      sr_d  = sr_q;
      acc_d = acc_q;
      if (i_clr) begin
         sr_d  = '0;
         acc_d = 1'b0;
      end else if (i_shift) begin
         // New bit enters at the MSB so LSB-first data ends up in place.
         sr_d        = sr_q >> 1;
         sr_d[W-1]   = i_bit;
         acc_d       = acc_q ^ i_bit;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sr_q  <= '0;
         acc_q <= 1'b0;
      end else begin
         sr_q  <= sr_d;
         acc_q <= acc_d;
      end
   end

   assign o_data = sr_q;
   assign o_acc  = acc_q;

endmodule

// File: rtl/serial_word_rx.sv
// Frame receiver: start / W data bits LSB first / optional even parity / stop.
// Good words are presented on o_data with a one-cycle o_load strobe.
module serial_word_rx
   import serial_rx_pkg::*;
#(
   parameter int W         = 4,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_sin,
   input  logic         i_sample_en,
   output logic [W-1:0] o_data,
   output logic         o_load,
   output logic         o_parity_err,
   output logic         o_frame_err,
   output logic         o_busy
);

   localparam int CW = $clog2(W + 1);

   rx_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic         perr_q, perr_d;
   logic [W-1:0] data_q, data_d;
   logic         load_q, load_d;
   logic         perr_pulse_q, perr_pulse_d;
   logic         ferr_q, ferr_d;

   logic         sr_clr, sr_shift, sr_acc;
   logic [W-1:0] sr_data;

   rx_shift_reg #(.W(W)) u_shift (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (sr_clr),
      .i_shift (sr_shift),
      .i_bit   (i_sin),
      .o_data  (sr_data),
      .o_acc   (sr_acc)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      perr_d       = perr_q;
      data_d       = data_q;
      load_d       = 1'b0;
      perr_pulse_d = 1'b0;
      ferr_d       = 1'b0;
      sr_clr       = 1'b0;
      sr_shift     = 1'b0;
      if (i_sample_en) begin
         case (state_q)
            IDLE: begin
               if (i_sin == START_BIT) begin
                  state_d = DATA;
                  cnt_d   = '0;
                  perr_d  = 1'b0;
                  sr_clr  = 1'b1;
               end
            end
            DATA: begin
               sr_shift = 1'b1;
               cnt_d    = cnt_q + CW'(1);
               if (cnt_q == CW'(W - 1)) begin
                  state_d = PARITY_EN ? PARITY : STOP;
               end
            end
            PARITY: begin
               perr_d  = sr_acc ^ i_sin;
               state_d = STOP;
            end
            STOP: begin
               // A bad stop bit outranks a parity mismatch.
               if (i_sin == SIN_IDLE) begin
                  state_d = IDLE;
                  if (perr_q) begin
                     perr_pulse_d = 1'b1;
                  end else begin
                     data_d = sr_data;
                     load_d = 1'b1;
                  end
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end
            BREAK: begin
               if (i_sin == SIN_IDLE) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         perr_q       <= 1'b0;
         data_q       <= '0;
         load_q       <= 1'b0;
         perr_pulse_q <= 1'b0;
         ferr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         perr_q       <= perr_d;
         data_q       <= data_d;
         load_q       <= load_d;
         perr_pulse_q <= perr_pulse_d;
         ferr_q       <= ferr_d;
      end
   end

   assign o_data       = data_q;
   assign o_load       = load_q;
   assign o_parity_err = perr_pulse_q;
   assign o_frame_err  = ferr_q;
   assign o_busy       = (state_q != IDLE);

endmodule
